// File: rtl/lb_sched_pkg.sv
// Shared definitions for the depthwise line-buffer layer scheduler:
// FSM encoding and descriptor dimension limits.
package lb_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int MIN_DIM = 3;
  localparam int MAX_DIM = 224;

  // A 3x3 window needs at least three rows and three columns.
  function automatic logic dims_ok(input logic [7:0] w, input logic [7:0] h);
    return (w >= 8'(MIN_DIM)) && (h >= 8'(MIN_DIM));
  endfunction

endpackage

// File: rtl/lb_rdlat_pipe.sv
// Valid shift register that realigns the feature-memory read strobe with
// the returning read data.
module lb_rdlat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vld,
  output logic o_vld
);

  logic [RD_LAT-1:0] r_vld_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  assign o_vld = r_vld_sr[RD_LAT-1];

endmodule

// File: rtl/lb_layer_scheduler.sv
// Per-layer sequencer: programs the 3x3 line buffer, streams the feature map
// in raster order and tags every 3-line output beat with window position.
module lb_layer_scheduler
  import lb_sched_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int P_CH      = 32,
  parameter int FM_AWIDTH = 16,
  parameter int RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FM_AWIDTH-1:0]   cfg_base,
  input  logic [7:0]             cfg_width,
  input  logic [7:0]             cfg_height,
  input  logic                   cfg_stride2,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic                   cfg_err,
  output logic                   fm_rd_en,
  output logic [FM_AWIDTH-1:0]   fm_rd_addr,
  input  logic [DWIDTH*P_CH-1:0] fm_rd_data,
  output logic [7:0]             lb_width,
  output logic [7:0]             lb_height,
  output logic                   lb_cfg_valid,
  output logic [DWIDTH*P_CH-1:0] lb_pix,
  output logic                   lb_pix_valid,
  input  logic                   lb_line3_valid,
  output logic                   win_valid,
  output logic [7:0]             win_row,
  output logic [7:0]             win_col,
  output logic                   win_left,
  output logic                   win_right,
  output logic                   win_keep,
  output logic                   busy,
  output logic                   done,
  output logic                   proto_err
);

  state_t               r_state, w_next;
  logic [FM_AWIDTH-1:0] r_base;
  logic [7:0]           r_w, r_h, r_row, r_col;
  logic                 r_s2;
  logic [15:0]          r_pix, r_total, r_beats, r_exp;
  logic                 w_cfg_ok, w_act, w_beat_ok, w_rd_en, w_pix_vld, w_accept;

  assign w_cfg_ok  = dims_ok(cfg_width, cfg_height);
  assign w_act     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  // Beats past the expected count are protocol errors, not windows.
  assign w_beat_ok = lb_line3_valid && w_act && (r_beats != r_exp);
  assign w_accept  = (r_state == ST_IDLE) && cfg_valid && w_cfg_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_rd_en      = 1'b0;
    cfg_ready    = 1'b0;
    cfg_err      = 1'b0;
    lb_cfg_valid = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (w_cfg_ok) w_next  = ST_CONFIG;
          else          cfg_err = 1'b1;
        end
      end
      ST_CONFIG: begin
        lb_cfg_valid = 1'b1;
        w_next       = ST_FETCH;
      end
      ST_FETCH: begin
        w_rd_en = 1'b1;
        if (r_pix == r_total - 16'd1) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_beats == r_exp) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_s2    <= 1'b0;
      r_total <= '0;
      r_exp   <= '0;
      r_pix   <= '0;
      r_beats <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_accept) begin
      r_base  <= cfg_base;
      r_w     <= cfg_width;
      r_h     <= cfg_height;
      r_s2    <= cfg_stride2;
      r_total <= 16'(cfg_width) * 16'(cfg_height);
      r_exp   <= 16'(cfg_height - 8'd2) * 16'(cfg_width);
      r_pix   <= '0;
      r_beats <= '0;
      r_row   <= 8'd1;
      r_col   <= '0;
    end else if (r_state == ST_DONE) begin
      r_pix   <= '0;
      r_beats <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      if (w_rd_en) r_pix <= r_pix + 16'd1;
      if (w_beat_ok) begin
        r_beats <= r_beats + 16'd1;
        if (r_col == r_w - 8'd1) begin
          r_col <= '0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  lb_rdlat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rdlat (
    .clk   (clk),
    .reset (reset),
    .i_vld (w_rd_en),
    .o_vld (w_pix_vld)
  );

  // Address wraps modulo 2^FM_AWIDTH; the adder carry is dropped.
  assign fm_rd_en     = w_rd_en;
  assign fm_rd_addr   = r_base + FM_AWIDTH'(r_pix);
  assign lb_pix_valid = w_pix_vld;
  assign lb_pix       = w_pix_vld ? fm_rd_data : '0;

  assign lb_width  = (r_state != ST_IDLE) ? r_w : '0;
  assign lb_height = (r_state != ST_IDLE) ? r_h : '0;
  assign busy      = (r_state != ST_IDLE);

  assign win_valid = w_beat_ok;
  assign proto_err = lb_line3_valid && !w_beat_ok;
  assign win_row   = w_act ? r_row : '0;
  assign win_col   = w_act ? r_col : '0;
  assign win_left  = w_act && (r_col == 8'd0);
  assign win_right = w_act && (r_col == r_w - 8'd1);
  // Stride 2 keeps windows centred on odd rows and even columns.
  assign win_keep  = w_act && (!r_s2 || (r_row[0] && !r_col[0]));

endmodule

// File: tb/tb_lb_layer_scheduler.sv
// Scoreboard bench for lb_layer_scheduler with a latency-accurate feature
// memory and a simple line-buffer beat generator.
module tb_lb_layer_scheduler;

  localparam int DW   = 8;
  localparam int PC   = 32;
  localparam int AW   = 16;
  localparam int RL   = 2;
  localparam int DATW = DW * PC;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   cfg_base;
  logic [7:0]      cfg_width, cfg_height;
  logic            cfg_stride2, cfg_valid, cfg_ready, cfg_err;
  logic            fm_rd_en;
  logic [AW-1:0]   fm_rd_addr;
  logic [DATW-1:0] fm_rd_data;
  logic [7:0]      lb_width, lb_height;
  logic            lb_cfg_valid;
  logic [DATW-1:0] lb_pix;
  logic            lb_pix_valid, lb_line3_valid, win_valid;
  logic [7:0]      win_row, win_col;
  logic            win_left, win_right, win_keep, busy, done, proto_err;

  always #5 clk = ~clk;

  lb_layer_scheduler #(
    .DWIDTH(DW), .P_CH(PC), .FM_AWIDTH(AW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_stride2(cfg_stride2), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
    .fm_rd_data(fm_rd_data), .lb_width(lb_width), .lb_height(lb_height),
    .lb_cfg_valid(lb_cfg_valid), .lb_pix(lb_pix), .lb_pix_valid(lb_pix_valid),
    .lb_line3_valid(lb_line3_valid), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .win_left(win_left), .win_right(win_right),
    .win_keep(win_keep), .busy(busy), .done(done), .proto_err(proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0]   addr_q[$];
  logic [DATW-1:0] pix_q[$];
  logic [18:0]     tag_q[$];
  logic [AW-1:0]   h_addr[RL];

  int   pix_cnt, cur_w, cyc, exp_w, exp_h;
  int   n_done, n_cfgerr, n_proto, n_lbcfg, first_rd, first_pv;
  logic beat_pend, inj_beat, extra_mode, extra_arm;

  function automatic logic [DATW-1:0] mem_word(input logic [AW-1:0] a);
    return {8{a, ~a}};
  endfunction

  task automatic chk(input string tag, input logic [DATW-1:0] obs, input logic [DATW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic next_beat;
    next_beat      = 1'b0;
    fm_rd_data     = mem_word(h_addr[RL-1]);
    lb_line3_valid = beat_pend | inj_beat;
    #1;
    if (fm_rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      if (addr_q.size() == 0) chk("rd_unexpected", fm_rd_en, 0);
      else chk("rd_addr", fm_rd_addr, addr_q.pop_front());
      pix_q.push_back(mem_word(fm_rd_addr));
    end
    if (lb_pix_valid) begin
      if (first_pv < 0) first_pv = cyc;
      if (pix_q.size() == 0) chk("pix_unexpected", lb_pix_valid, 0);
      else chk("pix_data", lb_pix, pix_q.pop_front());
      pix_cnt++;
      next_beat = (pix_cnt - 1 >= 2 * cur_w);
    end
    if (win_valid) begin
      if (tag_q.size() == 0) chk("win_unexpected", win_valid, 0);
      else begin
        chk("win_tag", {win_row, win_col, win_left, win_right, win_keep}, tag_q.pop_front());
        if (tag_q.size() == 0 && extra_mode) extra_arm = 1'b1;
      end
    end
    if (lb_cfg_valid) begin
      n_lbcfg++;
      chk("lb_width", lb_width, exp_w);
      chk("lb_height", lb_height, exp_h);
    end
    if (proto_err) chk("win_on_proto", win_valid, 0);
    n_done   += int'(done);
    n_cfgerr += int'(cfg_err);
    n_proto  += int'(proto_err);
    for (int i = RL - 1; i > 0; i--) h_addr[i] = h_addr[i-1];
    h_addr[0] = fm_rd_addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    beat_pend = next_beat;
    inj_beat  = extra_arm;
    extra_arm = 1'b0;
  endtask

  task automatic load_exp(input logic [AW-1:0] base, input int w, input int h, input logic s2);
    logic [18:0] t;
    logic        k;
    exp_w = w; exp_h = h; cur_w = w; pix_cnt = 0;
    for (int i = 0; i < w * h; i++) addr_q.push_back(base + AW'(i));
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 0; c < w; c++) begin
        k = s2 ? ((r % 2 == 1) && (c % 2 == 0)) : 1'b1;
        t = {8'(r), 8'(c), (c == 0), (c == w - 1), k};
        tag_q.push_back(t);
      end
    end
    n_done = 0; n_lbcfg = 0; n_proto = 0; first_rd = -1; first_pv = -1;
  endtask

  task automatic run_layer(input logic [AW-1:0] base, input int w, input int h,
                           input logic s2, input int exp_proto, input string nm);
    int budget;
    load_exp(base, w, h, s2);
    chk({nm, "_ready_idle"}, cfg_ready, 1);
    cfg_base = base; cfg_width = 8'(w); cfg_height = 8'(h);
    cfg_stride2 = s2; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    budget = 0;
    while (n_done == 0 && budget < 2000) begin
      tick();
      budget++;
    end
    tick();
    chk({nm, "_done_once"}, n_done, 1);
    chk({nm, "_lbcfg_once"}, n_lbcfg, 1);
    chk({nm, "_reads_left"}, addr_q.size(), 0);
    chk({nm, "_pix_left"}, pix_q.size(), 0);
    chk({nm, "_tags_left"}, tag_q.size(), 0);
    chk({nm, "_proto"}, n_proto, exp_proto);
    chk({nm, "_ready_after"}, cfg_ready, 1);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    cfg_base = '0; cfg_width = '0; cfg_height = '0; cfg_stride2 = 1'b0; cfg_valid = 1'b0;
    fm_rd_data = '0; lb_line3_valid = 1'b0;
    beat_pend = 1'b0; inj_beat = 1'b0; extra_mode = 1'b0; extra_arm = 1'b0;
    cyc = 0; pix_cnt = 0; cur_w = 3; exp_w = 0; exp_h = 0;
    n_done = 0; n_cfgerr = 0; n_proto = 0; n_lbcfg = 0; first_rd = -1; first_pv = -1;
    for (int i = 0; i < RL; i++) h_addr[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fm_rd_en, 0);
    chk("rst_lb_width", lb_width, 0);
    chk("rst_win_bits", {win_left, win_right, win_keep, win_valid, lb_pix_valid}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4x4 stride-1 layer
    run_layer(16'h0100, 4, 4, 1'b0, 0, "t1");
    chk("t1_pix_latency", first_pv - first_rd, RL);

    // Undersized descriptor is rejected
    n_cfgerr = 0; n_lbcfg = 0;
    cfg_width = 8'd2; cfg_height = 8'd5; cfg_valid = 1'b1;
    #1;
    chk("t2_cfg_err", cfg_err, 1);
    chk("t2_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    repeat (4) tick();
    chk("t2_err_count", n_cfgerr, 1);
    chk("t2_no_lbcfg", n_lbcfg, 0);
    chk("t2_busy", busy, 0);

    // Stride-2 keep pattern
    run_layer(16'h0000, 6, 6, 1'b1, 0, "t3");

    // Address wrap
    run_layer(16'hFFFE, 3, 3, 1'b0, 0, "t4");

    // Reset mid-FETCH aborts the layer
    load_exp(16'h0040, 8, 8, 1'b0);
    cfg_base = 16'h0040; cfg_width = 8'd8; cfg_height = 8'd8; cfg_stride2 = 1'b0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (10) tick();
    chk("t5_fetching", fm_rd_en, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_ready", cfg_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd_en", fm_rd_en, 0);
    chk("t5_rst_pixv", lb_pix_valid, 0);
    chk("t5_rst_width", {lb_width, lb_height}, 0);
    chk("t5_rst_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_no_done", n_done, 0);
    reset = 1'b0;
    addr_q.delete(); pix_q.delete(); tag_q.delete();
    for (int i = 0; i < RL; i++) h_addr[i] = '0;
    beat_pend = 1'b0;
    @(negedge clk);
    run_layer(16'h0300, 3, 3, 1'b0, 0, "t5_after");

    // Protocol errors: beat in IDLE, and one beat past the last expected
    n_proto = 0;
    inj_beat = 1'b1;
    tick();
    chk("t6_proto_idle", n_proto, 1);
    chk("t6_idle_busy", busy, 0);
    extra_mode = 1'b1;
    run_layer(16'h0200, 3, 3, 1'b0, 1, "t6_extra");
    extra_mode = 1'b0;
    run_layer(16'h0500, 4, 3, 1'b0, 0, "t6_clean");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_layer_scheduler.md
Name: lb_layer_scheduler

Overview:
- Per-layer sequencer for the 3x3 depthwise line buffer.
- Accepts one layer descriptor (base address, width, height, stride) and programs the line buffer's width/height.
- Streams the feature map out of feature memory in raster order, with fixed read latency, into the line buffer's pixel input.
- Tags every line-buffer 3-line output beat with window row/column, edge and stride-keep flags for the downstream DWC engine.

Parameters:
- DWIDTH, 8, bits per channel element
- P_CH, 32, channels per pixel word
- FM_AWIDTH, 16, feature-memory word address width (224*224 = 50176 fits)
- RD_LAT, 2, feature-memory read latency in cycles (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cfg_base  in  FM_AWIDTH  first pixel word address of the layer
- cfg_width  in  8  feature width W
- cfg_height  in  8  feature height H
- cfg_stride2  in  1  0 = stride 1, 1 = stride 2
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  scheduler idle, accepts descriptor
- cfg_err  out  1  one-cycle pulse: descriptor rejected
- fm_rd_en  out  1  feature-memory read strobe
- fm_rd_addr  out  FM_AWIDTH  feature-memory read address
- fm_rd_data  in  DWIDTH*P_CH  read data, valid RD_LAT cycles after fm_rd_en
- lb_width  out  8  width to line buffer
- lb_height  out  8  height to line buffer
- lb_cfg_valid  out  1  one-cycle pulse; drives both the width-valid and height-valid inputs
- lb_pix  out  DWIDTH*P_CH  pixel to line buffer
- lb_pix_valid  out  1  pixel valid
- lb_line3_valid  in  1  line buffer output beat valid
- win_valid  out  1  tag valid, same cycle as lb_line3_valid
- win_row  out  8  center row of window, 1..H-2
- win_col  out  8  column, 0..W-1
- win_left, win_right  out  1 each  col==0 / col==W-1
- win_keep  out  1  window belongs to strided output
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of layer
- proto_err  out  1  one-cycle pulse: unexpected lb_line3_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except cfg_ready=1.
  - State IDLE; all counters 0; read-valid pipeline cleared.
- A reset mid-layer aborts the layer immediately. No done pulse is issued.
- FSM states: IDLE, CONFIG, FETCH, DRAIN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with W<3 or H<3: pulse cfg_err, stay IDLE.
  - Otherwise capture base, W, H, stride2, then go to CONFIG.
  - cfg_valid is ignored in every state other than IDLE.
- CONFIG (1 cycle):
  - lb_cfg_valid=1, with lb_width=W and lb_height=H.
  - lb_width/lb_height hold the captured values until DONE; they are 0 in IDLE.
  - Next state FETCH.
- FETCH:
  - fm_rd_en=1 every cycle; fm_rd_addr = base + pixel counter.
  - The pixel counter runs 0..W*H-1; the address wraps modulo 2^FM_AWIDTH.
  - First read occurs the cycle after lb_cfg_valid.
  - The cycle the last read issues, go to DRAIN.
- Pixel path:
  - lb_pix_valid = fm_rd_en delayed by RD_LAT cycles, via a shift register.
  - lb_pix is fm_rd_data passed combinationally. No extra register.
  - The line buffer has no backpressure; reads are never paused.
- Tag counters (active in FETCH and DRAIN):
  - Each lb_line3_valid beat increments col. At col==W-1, col wraps to 0 and row increments.
  - Row starts at 1. Expected beats = (H-2)*W.
- DRAIN:
  - Wait until the expected beat count is reached.
  - The last beat may arrive in the same cycle that FETCH ends. That cycle is counted, and DRAIN lasts 1 cycle.
- DONE:
  - done=1 for one cycle; clear counters; next state IDLE.
- Tag outputs:
  - win_valid = lb_line3_valid gated by state in {FETCH, DRAIN}.
  - win_row, win_col, win_left, win_right, win_keep are driven combinationally from the counters.
  - win_keep = 1 when stride2=0.
  - When stride2=1, win_keep = (row odd) & (col even).
- proto_err pulses when lb_line3_valid arrives in IDLE, CONFIG or DONE, or after the expected count is reached. Such a beat never asserts win_valid and never moves the counters.
- Widths: W*H product is 16 bits; counters are 8 bits. The address adder is FM_AWIDTH wide, with the carry dropped.

Decomposition:
- Shared package lb_sched_pkg:
  - state encoding (IDLE=0, CONFIG=1, FETCH=2, DRAIN=3, DONE=4)
  - MIN_DIM=3
  - MAX_DIM=224
- One natural sub-module: lb_rdlat_pipe, an RD_LAT-deep valid shift register with asynchronous active-high reset.

Test Plan:
1. W=4, H=4, base=0x0100, stride 1, RD_LAT=2:
   - 16 reads at 0x0100..0x010F.
   - lb_pix_valid starts 2 cycles after the first fm_rd_en.
   - 8 beats tagged rows 1..2, cols 0..3, win_left at col 0, win_right at col 3; done once.
2. W=2, H=5 -> cfg_err pulse, cfg_ready stays 1, no lb_cfg_valid, no reads.
3. W=6, H=6, stride2=1:
   - win_keep=1 only at (row 1, cols 0/2/4) and (row 3, cols 0/2/4).
   - All other beats have win_keep=0.
4. base=0xFFFE, W=3, H=3 -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0006; 3 tagged beats; done.
5. Reset asserted mid-FETCH of a W=8, H=8 layer:
   - Outputs are 0 and cfg_ready=1 in the same cycle; no done pulse.
   - A new W=3, H=3 descriptor then completes normally.
6. lb_line3_valid in IDLE, and one extra beat after the last expected beat -> proto_err pulses, win_valid stays 0, counters unchanged.
